// File: rtl/fpu_uart_pkg.sv
// Shared UART definitions for the FPU host link (receive and transmit paths).
package fpu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS     = 8;
    localparam logic        UART_START_BIT     = 1'b0;
    localparam logic        UART_STOP_BIT      = 1'b1;
    localparam logic [7:0]  FPU_TX_HEADER_BYTE = 8'hA5;

    // A zero bit period would never terminate a bit; run it as one clock.
    function automatic logic [15:0] cpb_sanitize(input logic [15:0] cpb);
        return (cpb == 16'd0) ? 16'd1 : cpb;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser. ready_o is also high during the last clock of the
// stop bit so a new start_i chains the next frame with no idle bit.
module uart_tx_byte
    import fpu_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  data_i,
    input  logic [15:0] cpb_i,
    output logic        tx_o,
    output logic        ready_o
);

    uart_state_e state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] cpb_q, cpb_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    assign bit_end = (baud_q == cpb_q - 16'd1);
    assign ready_o = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        cpb_d   = cpb_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: baud_d = '0;
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = UART_STOP_BIT;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = UART_STOP_BIT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ready_o && start_i) begin
            state_d = START;
            baud_d  = '0;
            cpb_d   = cpb_sanitize(cpb_i);
            shreg_d = data_i;
            tx_d    = UART_START_BIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            cpb_q   <= 16'd1;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= UART_STOP_BIT;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            cpb_q   <= cpb_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/fpu_result_uart_tx.sv
// Serialises FPU result words over UART 8N1 with a one-deep pending buffer.
// Define FPU_TX_HEADER_EN to prefix each word with a sync byte.
module fpu_result_uart_tx
    import fpu_uart_pkg::*;
#(
    parameter int unsigned BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               result_valid_i,
    input  logic [8*BYTES-1:0] result_i,
    input  logic [15:0]        clks_per_bit_i,
    output logic               tx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               overrun_o
);

`ifdef FPU_TX_HEADER_EN
    localparam int unsigned HDR_FRAMES = 1;
`else
    localparam int unsigned HDR_FRAMES = 0;
`endif
    localparam int unsigned WW   = 8 * BYTES;
    localparam int unsigned NFR  = BYTES + HDR_FRAMES;
    localparam int unsigned IW   = $clog2(NFR + 1);
    localparam logic [IW-1:0] LAST = IW'(NFR - 1);

    logic          busy_q, busy_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] word_q, word_d;
    logic [15:0]   cpb_q, cpb_d;
    logic [WW-1:0] pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic          overrun_q, overrun_d;
    logic          done_q, done_d;

    logic          byte_start, byte_ready;
    logic [7:0]    byte_data;
    logic [15:0]   byte_cpb;
    logic          frame_end, last_frame, launch;
    logic [WW-1:0] launch_word;

    function automatic logic [7:0] frame_byte(input logic [WW-1:0] w, input logic [IW-1:0] idx);
        logic [IW-1:0] sel;
        sel = idx - IW'(HDR_FRAMES);
        if ((HDR_FRAMES != 0) && (idx == '0)) return FPU_TX_HEADER_BYTE;
        return 8'(w >> {sel, 3'b000});
    endfunction

    assign frame_end  = busy_q && byte_ready;
    assign last_frame = frame_end && (idx_q == LAST);

    always_comb begin
        busy_d      = busy_q;
        idx_d       = idx_q;
        word_d      = word_q;
        cpb_d       = cpb_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        done_d      = 1'b0;
        byte_start  = 1'b0;
        byte_data   = '0;
        byte_cpb    = cpb_q;
        launch      = 1'b0;
        launch_word = '0;

        if (frame_end && !last_frame) begin
            idx_d      = idx_q + IW'(1);
            byte_start = 1'b1;
            byte_data  = frame_byte(word_q, idx_d);
        end

        // On word completion the pending word has priority; a coincident strobe
        // then refills pending instead of counting as an overrun.
        if (last_frame) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            if (pend_full_q) begin
                launch      = 1'b1;
                launch_word = pend_q;
                pend_full_d = result_valid_i;
                if (result_valid_i) pend_d = result_i;
            end else if (result_valid_i) begin
                launch      = 1'b1;
                launch_word = result_i;
            end
        end else if (!busy_q) begin
            if (result_valid_i) begin
                launch      = 1'b1;
                launch_word = result_i;
            end
        end else if (result_valid_i) begin
            pend_d      = result_i;
            pend_full_d = 1'b1;
            if (pend_full_q) overrun_d = 1'b1;
        end

        if (launch) begin
            busy_d     = 1'b1;
            idx_d      = '0;
            word_d     = launch_word;
            cpb_d      = cpb_sanitize(clks_per_bit_i);
            byte_start = 1'b1;
            byte_cpb   = cpb_d;
            byte_data  = frame_byte(launch_word, '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            idx_q       <= '0;
            word_q      <= '0;
            cpb_q       <= 16'd1;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            cpb_q       <= cpb_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

    uart_tx_byte u_byte (
        .clk     (clk),
        .rst     (rst),
        .start_i (byte_start),
        .data_i  (byte_data),
        .cpb_i   (byte_cpb),
        .tx_o    (tx_o),
        .ready_o (byte_ready)
    );

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed bench for fpu_result_uart_tx; checks every tx_o bit cycle against a bit-stream model.
module tb_fpu_result_uart_tx;

`ifdef FPU_TX_HEADER_EN
    localparam int unsigned NFR = 5;
    localparam int unsigned HDR = 1;
`else
    localparam int unsigned NFR = 4;
    localparam int unsigned HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        result_valid_i = 1'b0;
    logic [31:0] result_i = '0;
    logic [15:0] clks_per_bit_i = 16'd4;
    logic        tx_o, busy_o, done_o, overrun_o;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    logic [31:0] words[4];
    int unsigned nwords;
    int unsigned inj_at[4];
    logic [31:0] inj_w[4];
    int unsigned ninj;

    fpu_result_uart_tx #(.BYTES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .result_valid_i (result_valid_i),
        .result_i       (result_i),
        .clks_per_bit_i (clks_per_bit_i),
        .tx_o           (tx_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk = ~clk;

    // Expected line level at sample j (j=1 is the first cycle after the strobe).
    function automatic logic exp_tx(input int unsigned j, input int unsigned cpb);
        int unsigned slot, w, f, b;
        logic [7:0]  by;
        if (j > nwords * 10 * NFR * cpb) return 1'b1;
        slot = (j - 1) / cpb;
        w    = slot / (10 * NFR);
        f    = (slot % (10 * NFR)) / 10;
        b    = slot % 10;
        if (HDR == 1 && f == 0) by = 8'hA5;
        else                    by = 8'(words[w] >> (8 * (f - HDR)));
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    task automatic run_stream(input logic [31:0] first, input logic [15:0] cpb_in,
                              input int unsigned cpb, input string name);
        int unsigned wc, total;
        logic e_tx, e_busy, e_done;
        wc    = 10 * NFR * cpb;
        total = nwords * wc;
        clks_per_bit_i = cpb_in;
        result_i       = first;
        result_valid_i = 1'b1;
        for (int unsigned j = 1; j <= total + 1; j++) begin
            @(negedge clk);
            result_valid_i = 1'b0;
            result_i       = $urandom;
            for (int unsigned k = 0; k < ninj; k++) begin
                if (inj_at[k] == j) begin
                    result_valid_i = 1'b1;
                    result_i       = inj_w[k];
                end
            end
            e_tx   = exp_tx(j, cpb);
            e_busy = (j <= total);
            e_done = (j > 1) && ((j - 1) % wc == 0);
            tests_run++;
            if (tx_o !== e_tx) begin
                tests_failed++;
                $display("FAIL %s tx_o at cycle %0d: got %b expected %b", name, j, tx_o, e_tx);
            end
            tests_run++;
            if (busy_o !== e_busy) begin
                tests_failed++;
                $display("FAIL %s busy_o at cycle %0d: got %b expected %b", name, j, busy_o, e_busy);
            end
            tests_run++;
            if (done_o !== e_done) begin
                tests_failed++;
                $display("FAIL %s done_o at cycle %0d: got %b expected %b", name, j, done_o, e_done);
            end
        end
        result_valid_i = 1'b0;
        ninj = 0;
    endtask

    task automatic check_overrun(input logic exp, input string name);
        tests_run++;
        if (overrun_o !== exp) begin
            tests_failed++;
            $display("FAIL %s overrun_o: got %b expected %b", name, overrun_o, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx_o, busy_o, done_o, overrun_o} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_values {tx,busy,done,ovr}: got %b expected 1000",
                     {tx_o, busy_o, done_o, overrun_o});
        end
        rst = 1'b0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            tests_run++;
            if ({tx_o, busy_o, done_o, overrun_o} !== 4'b1000) begin
                tests_failed++;
                $display("FAIL idle cycle %0d {tx,busy,done,ovr}: got %b expected 1000",
                         i, {tx_o, busy_o, done_o, overrun_o});
            end
        end
    endtask

    task automatic test_single;
        words[0] = 32'h3FC00000;
        nwords = 1;
        ninj = 0;
        run_stream(32'h3FC00000, 16'd4, 4, "single");
        check_overrun(1'b0, "single");
    endtask

    task automatic test_back_to_back;
        words[0] = 32'h40490FDB;
        words[1] = 32'hBF800000;
        nwords = 2;
        inj_at[0] = 50; inj_w[0] = 32'hBF800000;
        ninj = 1;
        run_stream(32'h40490FDB, 16'd4, 4, "back_to_back");
        check_overrun(1'b0, "back_to_back");
    endtask

    task automatic test_simultaneous;
        // Strobe coincides with word completion, pending empty: direct launch.
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        nwords = 2;
        inj_at[0] = 160; inj_w[0] = 32'h55667788;
        ninj = 1;
        run_stream(32'h11223344, 16'd4, 4, "simul_empty");
        // Pending full at completion: pending launches, new word refills pending.
        words[0] = 32'hA1A2A3A4;
        words[1] = 32'hB1B2B3B4;
        words[2] = 32'hC1C2C3C4;
        nwords = 3;
        inj_at[0] = 20;  inj_w[0] = 32'hB1B2B3B4;
        inj_at[1] = 160; inj_w[1] = 32'hC1C2C3C4;
        ninj = 2;
        run_stream(32'hA1A2A3A4, 16'd4, 4, "simul_full");
        check_overrun(1'b0, "simul_full");
    endtask

    task automatic test_overrun;
        words[0] = 32'h0000AAAA;
        words[1] = 32'hCCCC0000;
        nwords = 2;
        inj_at[0] = 20; inj_w[0] = 32'hBBBBBBBB;
        inj_at[1] = 60; inj_w[1] = 32'hCCCC0000;
        ninj = 2;
        run_stream(32'h0000AAAA, 16'd4, 4, "overrun");
        check_overrun(1'b1, "overrun_set");
        repeat (10) @(negedge clk);
        check_overrun(1'b1, "overrun_held");
    endtask

    task automatic test_reset_mid;
        words[0] = 32'h12003456;
        nwords = 1;
        clks_per_bit_i = 16'd4;
        result_i       = 32'h12003456;
        result_valid_i = 1'b1;
        for (int unsigned j = 1; j <= 98; j++) begin
            @(negedge clk);
            result_valid_i = 1'b0;
        end
        // Sample 98 sits in data bit 3 of byte 2 (0x00), so the line is low.
        tests_run++;
        if (tx_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid pre tx_o: got %b expected 0", tx_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({tx_o, busy_o, done_o, overrun_o} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_mid post {tx,busy,done,ovr}: got %b expected 1000",
                     {tx_o, busy_o, done_o, overrun_o});
        end
        repeat (3) @(negedge clk);
        words[0] = 32'hC0DE0A5F;
        nwords = 1;
        ninj = 0;
        run_stream(32'hC0DE0A5F, 16'd3, 3, "after_reset");
        check_overrun(1'b0, "after_reset");
    endtask

    task automatic test_cpb0;
        words[0] = 32'h00000001;
        nwords = 1;
        ninj = 0;
        run_stream(32'h00000001, 16'd0, 1, "cpb0");
    endtask

    initial begin
        ninj = 0;
        nwords = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_simultaneous();
        test_overrun();
        test_reset_mid();
        test_cpb0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fpu_result_uart_tx.md
# fpu_result_uart_tx

Downstream stage of the single-precision FPU: takes each 32-bit result strobed out of the FPU FSM top and serialises it back to the host over UART 8N1, using the same runtime CLKS_PER_BIT as the receive path. Sits in the user project wrapper between the FPU result bus and a tx pad / LA bit. Provides a one-deep pending buffer so a result arriving mid-transmission is not lost, plus a sticky overrun flag.

## Interface
- BYTES, 4: bytes per result word; fixed at 4 for FPU SP, parameter kept for reuse.
- clk  input  1  single clock domain for the block.
- rst  input  1  synchronous, active-high reset.
- result_valid_i  input  1  one-cycle strobe: result_i holds a new FPU result.
- result_i  input  32  FPU_sp_result word.
- clks_per_bit_i  input  16  clocks per UART bit.
- tx_o  output  1  UART serial out, idle high.
- busy_o  output  1  high while a word is being shifted out.
- done_o  output  1  one-cycle pulse when the last stop bit of a word completes.
- overrun_o  output  1  sticky: a pending result was overwritten before transmission.

## Operation
- Frame: start bit (0), 8 data bits LSB-first, 1 stop bit (1); no gap between bytes of a word.
- Byte order: byte0 = result_i[7:0] first, byte3 = result_i[31:24] last.
- FSM states: IDLE, START, DATA, STOP. IDLE -> START on launch; START -> DATA after one bit time; DATA -> STOP after 8 bit times; STOP -> START if bytes remain, else IDLE (or START of pending word).
- Launch: in IDLE, result_valid_i loads shift word, sets busy_o. Word captured at launch; later changes on result_i ignored.
- clks_per_bit_i sampled at launch only and held for the whole word; value 0 treated as 1.
- Pending buffer: result_valid_i while busy -> word stored in pending, pending_full set. On word completion, pending word launches in the following bit slot with no idle bit.
- Overrun: result_valid_i while busy and pending_full -> pending overwritten with new word, overrun_o set; cleared only by rst.
- Simultaneous completion and result_valid_i: if pending empty, new word launches directly; if pending full, pending launches and new word enters pending (no overrun).
- Reset mid-frame: next cycle tx_o=1, busy_o=0, done_o=0, overrun_o=0, pending cleared, FSM IDLE; partial frame abandoned.

## Timing
- Reset values: tx_o=1, busy_o=0, done_o=0, overrun_o=0.
- tx_o registered: result_valid_i at cycle N -> tx_o=0 and busy_o=1 from cycle N+1.
- Each bit held exactly CPB clocks; word = 10*BYTES*CPB clocks (40*CPB), header build 50*CPB.
- done_o high in the single cycle after the final stop bit's last clock; busy_o drops that same cycle unless a pending word launches (then busy_o stays 1, tx_o=0).

## Configuration
- FPU_TX_HEADER_EN: when defined, each word is preceded by a sync byte 8'hA5 framed identically (5 frames per word, 50*CPB clocks). When undefined, only the 4 result bytes are sent (40*CPB clocks). done_o, pending and overrun behaviour unchanged.

## Structure
- Shared package fpu_uart_pkg: FSM state enum, UART_DATA_BITS=8, UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, FPU_TX_HEADER_BYTE=8'hA5; shared with the receive path.
- One natural sub-module: uart_tx_byte (single-byte 8N1 serialiser with bit counter and baud counter, start/ready handshake); top handles word sequencing, pending buffer, overrun, done.

## Test plan
- Reset then idle 100 cycles -> tx_o=1, busy_o=0, done_o=0, overrun_o=0 throughout.
- CPB=4, result 32'h3FC00000 strobed -> tx_o low next cycle; bytes 00,00,C0,3F decoded, each bit 4 clocks; done_o pulse at cycle 161 after strobe; busy_o falls same cycle.
- CPB=4, send 32'h40490FDB, second strobe 32'hBF800000 mid-word -> second word starts immediately after first stop bit, no idle gap, overrun_o stays 0, two done_o pulses.
- Three strobes in one word time (A, B, C) -> A then C transmitted, B dropped, overrun_o=1 and held until rst.
- rst asserted mid-DATA of byte 2 -> tx_o=1, busy_o=0 next cycle; subsequent strobe transmits cleanly from byte0.
- FPU_TX_HEADER_EN defined, CPB=0 (treated as 1), result 32'h00000001 -> frames A5,01,00,00,00 at 1 clock/bit, done_o at cycle 51 after strobe.
